// File: rtl/sine_dds_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sine_dds_ctrl
// Purpose  : Phase-accumulator DDS controller that addresses an external
//            combinational sine LUT and delivers attenuated samples over a
//            valid/ready handshake. Optional LFSR phase dither: DDS_DITHER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sine_dds_ctrl #(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic [PHASE_W-1:0]  i_ftw,
    input  logic                i_ftw_load,
    input  logic                i_phase_clr,
    input  logic [3:0]          i_atten,
    input  logic                i_sample_req,
    output logic [ADDR_W-1:0]   o_lut_addr,
    input  logic [DATA_W-1:0]   i_lut_data,
    output logic [DATA_W-1:0]   o_sample,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        CAPT  = 2'd2,
        VALID = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_start;
    logic                 w_pending_nxt;
    logic                 w_overrun_set;

    logic [PHASE_W-1:0]   r_phase;
    logic [PHASE_W-1:0]   r_ftw;
    logic [PHASE_W-1:0]   w_addr_phase;
    logic [ADDR_W-1:0]    r_lut_addr;
    logic [DATA_W-1:0]    r_sample;
    logic [DATA_W-1:0]    w_scaled;
    logic                 r_valid;
    logic                 r_pending;
    logic                 r_overrun;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state, request queueing and overrun detection
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_start       = 1'b0;
        w_pending_nxt = r_pending;
        w_overrun_set = 1'b0;
        case (r_state)
            IDLE: begin
                // Requests seen while disabled in IDLE are simply dropped.
                if (i_en && (i_sample_req || r_pending)) begin
                    w_state_nxt   = ADDR;
                    w_start       = 1'b1;
                    // A fresh request arriving alongside a queued one stays queued.
                    w_pending_nxt = r_pending && i_sample_req;
                end
            end
            ADDR:  w_state_nxt = CAPT;
            CAPT:  w_state_nxt = VALID;
            VALID: begin
                if (i_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (r_state != IDLE && i_sample_req) begin
            if (r_pending) begin
                w_overrun_set = 1'b1;
            end else begin
                w_pending_nxt = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Phase accumulator and tuning word
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ftw <= '0;
        end else if (i_ftw_load) begin
            r_ftw <= i_ftw;
        end
    end

    // Clear wins over the CAPT increment; the increment always uses the FTW
    // held before any same-cycle load.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_phase <= '0;
        end else if (i_phase_clr) begin
            r_phase <= '0;
        end else if (r_state == CAPT) begin
            r_phase <= r_phase + r_ftw;
        end
    end

`ifdef DDS_DITHER_EN
    localparam logic [15:0]        c_LFSR_POLY = 16'hB400;
    localparam logic [15:0]        c_LFSR_SEED = 16'hACE1;
    localparam logic [PHASE_W-1:0] c_DITH_MASK = {PHASE_W{1'b1}} >> ADDR_W;

    logic [15:0] r_lfsr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_lfsr <= c_LFSR_SEED;
        end else if (r_state == CAPT) begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_LFSR_POLY : 16'h0000);
        end
    end

    // Dither perturbs only the address; the accumulator itself is untouched.
    always_comb begin
        w_addr_phase = r_phase + (PHASE_W'(r_lfsr) & c_DITH_MASK);
    end
`else
    always_comb begin
        w_addr_phase = r_phase;
    end
`endif

    // ------------------------------------------------------------------------
    // LUT address, sample capture and handshake
    // ------------------------------------------------------------------------
    always_comb begin
        w_scaled = DATA_W'($signed(i_lut_data) >>> i_atten);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_lut_addr <= '0;
            r_sample   <= '0;
            r_valid    <= 1'b0;
            r_pending  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end
            if (r_state == ADDR) begin
                r_lut_addr <= w_addr_phase[PHASE_W-1 -: ADDR_W];
            end
            if (r_state == CAPT) begin
                r_sample <= w_scaled;
                r_valid  <= 1'b1;
            end else if (r_state == VALID && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_lut_addr = r_lut_addr;
    assign o_sample   = r_sample;
    assign o_valid    = r_valid;
    assign o_overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sine_dds_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sine_dds_ctrl
// Purpose  : Directed self-checking bench for sine_dds_ctrl (default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sine_dds_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] ftw;
    logic        ftw_load;
    logic        phase_clr;
    logic [3:0]  atten;
    logic        sample_req;
    logic [9:0]  lut_addr;
    logic [15:0] lut_data;
    logic [15:0] sample;
    logic        valid;
    logic        ready;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    sine_dds_ctrl #(
        .PHASE_W (32),
        .ADDR_W  (10),
        .DATA_W  (16)
    ) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_ftw        (ftw),
        .i_ftw_load   (ftw_load),
        .i_phase_clr  (phase_clr),
        .i_atten      (atten),
        .i_sample_req (sample_req),
        .o_lut_addr   (lut_addr),
        .i_lut_data   (lut_data),
        .o_sample     (sample),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_overrun    (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_ftw(input logic [31:0] val);
        ftw      = val;
        ftw_load = 1'b1;
        tick();
        ftw_load = 1'b0;
    endtask

    // One complete sample with i_ready high: checks latency, address, sample, drop.
    task automatic do_req(input string tag, input logic [9:0] ea, input logic [15:0] es);
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        tick();
        check({tag, "_lat2"}, 32'(valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_addr"}, 32'(lut_addr), 32'(ea));
        check({tag, "_sample"}, 32'(sample), 32'(es));
        tick();
        check({tag, "_drop"}, 32'(valid), 32'd0);
        repeat (4) tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        ftw        = 32'h0;
        ftw_load   = 1'b0;
        phase_clr  = 1'b0;
        atten      = 4'd0;
        sample_req = 1'b0;
        lut_data   = 16'h1234;
        ready      = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_addr", 32'(lut_addr), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        // Slow tuning word: consecutive addresses
        load_ftw(32'h0040_0000);
        en = 1'b1;
        do_req("q0", 10'd0, 16'h1234);
        do_req("q1", 10'd1, 16'h1234);
        do_req("q2", 10'd2, 16'h1234);
        do_req("q3", 10'd3, 16'h1234);

        // Half-scale tuning word after a phase clear
        phase_clr = 1'b1;
        load_ftw(32'h8000_0000);
        phase_clr = 1'b0;
        do_req("h0", 10'd0, 16'h1234);
        do_req("h1", 10'd512, 16'h1234);
        do_req("h2", 10'd0, 16'h1234);
        do_req("h3", 10'd512, 16'h1234);

        // Preset phase to 0xFFC0_0000, then step across the wrap
        load_ftw(32'hFFC0_0000);
        do_req("w0", 10'd0, 16'h1234);
        load_ftw(32'h0040_0000);
        do_req("w1", 10'd1023, 16'h1234);
        do_req("w2", 10'd0, 16'h1234);

        // Attenuation with sign extension
        atten    = 4'd1;
        lut_data = 16'h7FFF;
        do_req("att_pos", 10'd1, 16'h3FFF);
        lut_data = 16'h8000;
        do_req("att_neg", 10'd2, 16'hC000);
        atten = 4'd15;
        do_req("att_max", 10'd3, 16'hFFFF);
        atten    = 4'd0;
        lut_data = 16'h0101;

        // FTW load during CAPT must not affect that increment
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        tick();
        check("ldc_addr", 32'(lut_addr), 32'd4);
        ftw      = 32'h8000_0000;
        ftw_load = 1'b1;
        tick();
        ftw_load = 1'b0;
        check("ldc_valid", 32'(valid), 32'd1);
        check("ldc_sample", 32'(sample), 32'h0101);
        tick();
        repeat (4) tick();
        do_req("ldc_n1", 10'd5, 16'h0101);
        do_req("ldc_n2", 10'd517, 16'h0101);

        // Phase clear wins over the CAPT increment
        load_ftw(32'h0040_0000);
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        tick();
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
        check("clr_addr", 32'(lut_addr), 32'd5);
        check("clr_valid", 32'(valid), 32'd1);
        tick();
        repeat (4) tick();
        do_req("clr_next", 10'd0, 16'h0101);

        // Requests with i_en low in IDLE are dropped silently
        en         = 1'b0;
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        repeat (4) tick();
        check("dis_valid", 32'(valid), 32'd0);
        check("dis_overrun", 32'(overrun), 32'd0);
        en = 1'b1;
        repeat (4) tick();
        check("dis_nopend", 32'(valid), 32'd0);

        // Dropping i_en mid-sample does not abort it
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        en         = 1'b0;
        tick();
        tick();
        check("inflt_valid", 32'(valid), 32'd1);
        check("inflt_addr", 32'(lut_addr), 32'd1);
        tick();
        en = 1'b1;
        repeat (4) tick();

        // Back-pressure: three requests while VALID -> one pending, overrun
        ready      = 1'b0;
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        tick();
        tick();
        check("bp_valid", 32'(valid), 32'd1);
        check("bp_addr", 32'(lut_addr), 32'd2);
        sample_req = 1'b1;
        tick();
        check("bp_ovr_first", 32'(overrun), 32'd0);
        tick();
        tick();
        sample_req = 1'b0;
        check("bp_overrun", 32'(overrun), 32'd1);
        check("bp_hold", 32'(valid), 32'd1);
        ready = 1'b1;
        tick();
        check("bp_drop", 32'(valid), 32'd0);
        tick();
        tick();
        tick();
        check("bp_pend_valid", 32'(valid), 32'd1);
        check("bp_pend_addr", 32'(lut_addr), 32'd3);
        tick();
        check("bp_pend_drop", 32'(valid), 32'd0);
        repeat (4) tick();
        check("bp_single", 32'(valid), 32'd0);
        check("bp_sticky", 32'(overrun), 32'd1);

        // Reset asserted while in CAPT
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rc_valid", 32'(valid), 32'd0);
        check("rc_sample", 32'(sample), 32'd0);
        check("rc_addr", 32'(lut_addr), 32'd0);
        check("rc_overrun", 32'(overrun), 32'd0);
        tick();
        check("rc_idle", 32'(valid), 32'd0);
        load_ftw(32'h0040_0000);
        do_req("rc_next", 10'd0, 16'h0101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sine_dds_ctrl.md
SINE_DDS_CTRL -- requirements
Module: sine_dds_ctrl

Interface
REQ-001 SHALL have parameter PHASE_W, default 32, phase accumulator width.
REQ-002 SHALL have parameter ADDR_W, default 10, sine LUT address width.
REQ-003 SHALL have parameter DATA_W, default 16, LUT word and sample width.
REQ-004 SHALL have port i_clk, input, 1, single clock; all logic rising-edge.
REQ-005 SHALL have port i_rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port i_en, input, 1, run enable; low blocks new sample acceptance.
REQ-007 SHALL have port i_ftw, input, PHASE_W, frequency tuning word.
REQ-008 SHALL have port i_ftw_load, input, 1, capture i_ftw into the active FTW register.
REQ-009 SHALL have port i_phase_clr, input, 1, zero the phase accumulator.
REQ-010 SHALL have port i_atten, input, 4, arithmetic right-shift applied to the sample.
REQ-011 SHALL have port i_sample_req, input, 1, one-cycle pulse per codec sample period.
REQ-012 SHALL have port o_lut_addr, output, ADDR_W, address to the combinational sine LUT.
REQ-013 SHALL have port i_lut_data, input, DATA_W, signed LUT word for o_lut_addr, valid in the same cycle.
REQ-014 SHALL have port o_sample, output, DATA_W, signed scaled sample.
REQ-015 SHALL have port o_valid, input-to-sink handshake output, 1, o_sample valid.
REQ-016 SHALL have port i_ready, input, 1, sink accepts o_sample when o_valid and i_ready are both high.
REQ-017 SHALL have port o_overrun, output, 1, sticky: a request was lost.

Function
REQ-018 FSM states SHALL be IDLE, ADDR, CAPT, VALID.
REQ-019 IDLE->ADDR SHALL occur when i_en=1 and (i_sample_req=1 or pending=1); pending clears on that transition.
REQ-020 In ADDR, o_lut_addr SHALL be registered from phase[PHASE_W-1 -: ADDR_W] (plus dither per REQ-031).
REQ-021 In CAPT, i_lut_data >>> i_atten (sign-extended) SHALL be registered into o_sample, and phase SHALL become phase + FTW modulo 2^PHASE_W; next state VALID.
REQ-022 In VALID, o_valid SHALL be 1 and o_sample stable; on i_ready=1 go to IDLE; o_valid SHALL drop the following cycle.
REQ-023 Latency SHALL be 3 cycles from i_sample_req in IDLE to o_valid=1.
REQ-024 i_sample_req outside IDLE SHALL set a one-deep pending flag; a request while pending is already set SHALL set o_overrun.
REQ-025 i_ftw_load SHALL update FTW in any state; a load in CAPT SHALL not affect that cycle's phase increment.
REQ-026 i_phase_clr SHALL zero the phase in any state and take priority over the CAPT increment in the same cycle.
REQ-027 i_en=0 SHALL not abort an in-flight sample; requests arriving with i_en=0 in IDLE SHALL be dropped without setting o_overrun.
REQ-028 Phase wrap SHALL be silent modular overflow.

Reset
REQ-029 i_rst_n=0 at a clock edge SHALL set state IDLE, phase 0, FTW 0, pending 0, o_lut_addr 0, o_sample 0, o_valid 0, o_overrun 0, from any state including mid-sample.
REQ-030 o_overrun SHALL clear only on reset.

Configuration
REQ-031 With DDS_DITHER_EN defined, a 16-bit Galois LFSR (poly 0xB400, seed 0xACE1, stepped once per CAPT) SHALL add its low (PHASE_W-ADDR_W) bits, truncated, to the phase before address extraction; the accumulated phase itself SHALL be unaltered.
REQ-032 Without DDS_DITHER_EN, the LFSR SHALL not exist and addressing SHALL be pure truncation.

Verification
REQ-033 FTW=0x0040_0000, 4 requests spaced 8 cycles -> o_lut_addr 0,1,2,3; o_valid 3 cycles after each request.
REQ-034 FTW=0x8000_0000 -> addresses 0,512,0,512; phase preset 0xFFC0_0000 with FTW=0x0040_0000 -> next address 0 (wrap).
REQ-035 LUT 0x7FFF with i_atten=1 -> o_sample 0x3FFF; LUT 0x8000 with i_atten=1 -> 0xC000.
REQ-036 i_ready held 0, 3 requests during VALID -> one pending served after handshake, o_overrun=1 and stays 1.
REQ-037 i_rst_n low during CAPT -> next cycle o_valid=0, o_sample=0, o_lut_addr=0; next request yields address 0.
REQ-038 i_phase_clr together with CAPT, FTW=0x0040_0000 -> phase 0; next address 0.
